// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin multiplexer.
// The search helper supports up to MAX_N channels.
package rr_mux_pkg;

   localparam int unsigned MAX_N     = 64;
   localparam int unsigned IDX_W     = 6;
   localparam int unsigned MAX_WIDTH = 1024;

   localparam logic [MAX_WIDTH-1:0] DATA_RST = '0;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } rr_pick_t;

   // First requester at or after ptr, wrapping modulo n.
   function automatic rr_pick_t rr_next(input int unsigned      n,
                                        input logic [IDX_W-1:0] ptr,
                                        input logic [MAX_N-1:0] req);
      rr_pick_t         pick;
      logic [IDX_W-1:0] c;
      pick = '0;
      for (int unsigned k = 0; k < MAX_N; k++) begin
         if (k < n && !pick.found) begin
            c = IDX_W'((32'(ptr) + k) % n);
            if (req[c]) begin
               pick.found = 1'b1;
               pick.idx   = c;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arb.sv
// N-way round-robin priority search returning a one-hot grant and its index.
// A held lock overrides the search and grants lock_ch unconditionally.
module rr_arb
   import rr_mux_pkg::*;
#(
   parameter  int unsigned N  = 4,
   localparam int unsigned SW = $clog2(N)
) (
   input  logic [SW-1:0] ptr,
   input  logic [N-1:0]  req,
   input  logic          lock,
   input  logic [SW-1:0] lock_ch,
   output logic [N-1:0]  gnt,
   output logic [SW-1:0] gnt_idx
);

   rr_pick_t pick;

   always_comb begin
      pick = rr_next(N, IDX_W'(ptr), MAX_N'(req));
   end

   always_comb begin
      gnt = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (lock) begin
            gnt[i] = (lock_ch == SW'(i));
         end else begin
            gnt[i] = pick.found && (pick.idx == IDX_W'(i));
         end
      end
   end

   always_comb begin
      gnt_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt[i]) begin
            gnt_idx |= SW'(i);
         end
      end
   end

endmodule

// File: rtl/rr_mux.sv
// Round-robin N:1 stream multiplexer with a registered output stage.
// Define RR_MUX_LOCK_EN to keep in_last-delimited packets together on the output.
module rr_mux
   import rr_mux_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned N     = 4,
   localparam int unsigned SW    = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_last,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_last,
   output logic [SW-1:0]      out_sel,
   input  logic               out_ready
);

   logic [SW-1:0]    ptr;
   logic [SW-1:0]    ptr_d;
   logic [SW-1:0]    ptr_inc;
   logic             lock;
   logic [SW-1:0]    lock_ch;
   logic [N-1:0]     gnt;
   logic [SW-1:0]    gnt_idx;
   logic             load;
   logic             xfer;
   logic [WIDTH-1:0] sel_data;
   logic             sel_last;

   rr_arb #(
      .N(N)
   ) u_arb (
      .ptr     (ptr),
      .req     (in_valid),
      .lock    (lock),
      .lock_ch (lock_ch),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign load = ~out_valid | out_ready;
   // rst_n in the gate keeps in_ready low for the whole reset assertion
   assign in_ready = gnt & in_valid & {N{en & load & rst_n}};
   assign xfer     = |in_ready;
   assign ptr_inc  = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (gnt[i]) begin
            sel_data |= in_data[i*WIDTH +: WIDTH];
            sel_last |= in_last[i];
         end
      end
   end

`ifdef RR_MUX_LOCK_EN
   logic          lock_d;
   logic [SW-1:0] lock_ch_d;

   always_comb begin
      ptr_d     = ptr;
      lock_d    = lock;
      lock_ch_d = lock_ch;
      if (xfer) begin
         if (sel_last) begin
            ptr_d  = ptr_inc;
            lock_d = 1'b0;
         end else begin
            lock_d    = 1'b1;
            lock_ch_d = gnt_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock    <= 1'b0;
         lock_ch <= '0;
      end else begin
         lock    <= lock_d;
         lock_ch <= lock_ch_d;
      end
   end
`else
   assign lock    = 1'b0;
   assign lock_ch = '0;

   // Without packet lock every accepted beat moves the pointer on
   always_comb begin
      ptr_d = ptr;
      if (xfer) begin
         ptr_d = ptr_inc;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= DATA_RST[WIDTH-1:0];
         out_last  <= 1'b0;
         out_sel   <= '0;
         ptr       <= '0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_sel   <= gnt_idx;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         ptr <= ptr_d;
      end
   end

endmodule

// File: tb/tb_rr_mux.sv
// Scoreboard bench for rr_mux: per-channel producer queues feed the DUT, expected
// output beats are queued up front and checked by an independent monitor.
module tb_rr_mux;

   localparam int unsigned N     = 4;
   localparam int unsigned WIDTH = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               en;
   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_last;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic               out_last;
   logic [1:0]         out_sel;
   logic               out_ready;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_out    = 0;
   logic [10:0] sb [$];
   logic [8:0]  chq [N][$];
   logic [N-1:0] acc = '0;

   always #5 clk = ~clk;

   rr_mux #(
      .WIDTH(WIDTH),
      .N    (N)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_beat(input int ch, input logic last, input logic [7:0] d);
      chq[ch].push_back({last, d});
   endtask

   task automatic expect_beat(input int ch, input logic last, input logic [7:0] d);
      logic [1:0] s;
      s = 2'(ch);
      sb.push_back({s, last, d});
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (chq[i].size() > 0) begin
            in_valid[i]                = 1'b1;
            in_last[i]                 = chq[i][0][8];
            in_data[i*WIDTH +: WIDTH] = chq[i][0][7:0];
         end else begin
            in_valid[i]                = 1'b0;
            in_last[i]                 = 1'b0;
            in_data[i*WIDTH +: WIDTH] = '0;
         end
      end
   endtask

   // Retire beats accepted at this edge, then present the next heads.
   task automatic cycle();
      logic [8:0] tmp;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i] && chq[i].size() > 0) tmp = chq[i].pop_front();
      end
      drive();
   endtask

   function automatic logic busy();
      logic b;
      b = out_valid || (sb.size() != 0);
      for (int i = 0; i < N; i++) if (chq[i].size() != 0) b = 1'b1;
      return b;
   endfunction

   task automatic run_until_idle(input string name);
      int k;
      k = 0;
      while (busy() && k < 60) begin
         cycle();
         k++;
      end
      check(name, 32'(busy()), 32'd0);
   endtask

   // Monitor: captures accepted inputs and checks every output transfer.
   initial begin
      logic [10:0] e;
      forever begin
         @(negedge clk);
         acc = in_valid & in_ready;
         if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL out_unexpected: got sel=%0d data=0x%0h, expected no beat",
                        out_sel, out_data);
            end else begin
               e = sb.pop_front();
               check("out_beat", {21'd0, out_sel, out_last, out_data}, {21'd0, e});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0;
      rst_n     = 1'b1;
      en        = 1'b1;
      out_ready = 1'b1;
      in_valid  = '0;
      in_last   = '0;
      in_data   = '0;
      #2 rst_n = 1'b0;
      #10;
      in_valid = 4'hF;
      in_last  = 4'hF;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_sel", 32'(out_sel), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      in_valid = '0;
      in_last  = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // All channels busy with single-beat packets: strict rotation, full rate
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) begin
            push_beat(i, 1'b1, 8'(16 * (r + 1) + i));
            expect_beat(i, 1'b1, 8'(16 * (r + 1) + i));
         end
      end
      drive();
      @(negedge clk);
      check("first_in_ready", 32'(in_ready), 32'h1);
      check("first_out_valid", 32'(out_valid), 32'd0);
      n0 = n_out;
      repeat (9) cycle();
      check("rr_throughput", 32'(n_out - n0), 32'd8);
      check("rr_idle_valid", 32'(out_valid), 32'd0);
      run_until_idle("drain_rr");

      // Lone channel 3, then lone channel 0: pointer wraps 3 -> 0
      push_beat(3, 1'b1, 8'hA5);
      expect_beat(3, 1'b1, 8'hA5);
      drive();
      @(negedge clk);
      check("ch3_in_ready", 32'(in_ready), 32'h8);
      run_until_idle("drain_ch3");
      push_beat(0, 1'b1, 8'h3C);
      expect_beat(0, 1'b1, 8'h3C);
      drive();
      @(negedge clk);
      check("ch0_in_ready", 32'(in_ready), 32'h1);
      run_until_idle("drain_ch0");

      // 3-beat packet on ch1 competing with single beats on ch2
      push_beat(1, 1'b0, 8'h31);
      push_beat(1, 1'b0, 8'h32);
      push_beat(1, 1'b1, 8'h33);
      push_beat(2, 1'b1, 8'h41);
      push_beat(2, 1'b1, 8'h42);
`ifdef RR_MUX_LOCK_EN
      expect_beat(1, 1'b0, 8'h31);
      expect_beat(1, 1'b0, 8'h32);
      expect_beat(1, 1'b1, 8'h33);
      expect_beat(2, 1'b1, 8'h41);
      expect_beat(2, 1'b1, 8'h42);
`else
      expect_beat(1, 1'b0, 8'h31);
      expect_beat(2, 1'b1, 8'h41);
      expect_beat(1, 1'b0, 8'h32);
      expect_beat(2, 1'b1, 8'h42);
      expect_beat(1, 1'b1, 8'h33);
`endif
      drive();
      run_until_idle("drain_pkt");

      // Output stall: no input accepted, data held; release drains and reloads together
      out_ready = 1'b0;
      push_beat(0, 1'b1, 8'h55);
      push_beat(1, 1'b1, 8'h66);
      expect_beat(0, 1'b1, 8'h55);
      expect_beat(1, 1'b1, 8'h66);
      drive();
      cycle();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_data", 32'(out_data), 32'h55);
         cycle();
      end
      n0 = n_out;
      out_ready = 1'b1;
      @(negedge clk);
      check("release_in_ready", 32'(in_ready), 32'h2);
      cycle();
      cycle();
      check("release_no_bubble", 32'(n_out - n0), 32'd2);
      check("release_idle_valid", 32'(out_valid), 32'd0);
      run_until_idle("drain_stall");

      // en low for 3 cycles after the first beat of a ch0 packet
      push_beat(0, 1'b0, 8'h71);
      push_beat(0, 1'b0, 8'h72);
      push_beat(0, 1'b1, 8'h73);
`ifdef RR_MUX_LOCK_EN
      expect_beat(0, 1'b0, 8'h71);
      expect_beat(0, 1'b0, 8'h72);
      expect_beat(0, 1'b1, 8'h73);
      expect_beat(1, 1'b1, 8'hA1);
`else
      expect_beat(0, 1'b0, 8'h71);
      expect_beat(1, 1'b1, 8'hA1);
      expect_beat(0, 1'b0, 8'h72);
      expect_beat(0, 1'b1, 8'h73);
`endif
      drive();
      cycle();
      en = 1'b0;
      push_beat(1, 1'b1, 8'hA1);
      drive();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("en_off_in_ready", 32'(in_ready), 32'd0);
         cycle();
      end
      en = 1'b1;
      @(negedge clk);
`ifdef RR_MUX_LOCK_EN
      check("en_on_in_ready", 32'(in_ready), 32'h1);
`else
      check("en_on_in_ready", 32'(in_ready), 32'h2);
`endif
      run_until_idle("drain_en");

      // Reset mid-packet: everything clears at once, ptr back to 0
      out_ready = 1'b0;
      push_beat(2, 1'b0, 8'hB1);
      push_beat(2, 1'b0, 8'hB2);
      push_beat(2, 1'b1, 8'hB3);
      drive();
      cycle();
      #2;
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      check("pre_rst_sel", 32'(out_sel), 32'd2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_sel", 32'(out_sel), 32'd0);
      check("mid_rst_out_data", 32'(out_data), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < N; i++) chq[i].delete();
      drive();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      push_beat(3, 1'b1, 8'hC3);
      push_beat(0, 1'b1, 8'hC0);
      expect_beat(0, 1'b1, 8'hC0);
      expect_beat(3, 1'b1, 8'hC3);
      drive();
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'h1);
      run_until_idle("drain_post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
